// File: rtl/top_proc_pkg.sv
// Shared types and constants for the multicycle RV32I-subset core.
// Holds opcodes, the 4-bit ALU-op encoding, FSM states, control bundle and immediate builder.
package top_proc_pkg;

    localparam logic [31:0] INITIAL_PC_DEFAULT = 32'h0040_0000;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SRA = 4'd7,
        ALU_SLT = 4'd8
    } aluOp_t;

    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EX  = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4
    } state_t;

    typedef struct packed {
        aluOp_t aluOp;
        logic   aluSrcImm;
        logic   regWrite;
        logic   memToReg;
        logic   memRead;
        logic   memWrite;
        logic   branchEq;
        logic   branchNe;
    } ctrl_t;

    // hiField is instr[31:20], loField is instr[11:7]
    function automatic logic [31:0] buildImm(input logic [6:0]  opcode,
                                             input logic [11:0] hiField,
                                             input logic [4:0]  loField);
        logic [31:0] imm;
        case (opcode)
            OP_STORE:  imm = {{20{hiField[11]}}, hiField[11:5], loField};
            OP_BRANCH: imm = {{19{hiField[11]}}, hiField[11], loField[0],
                              hiField[10:5], loField[4:1], 1'b0};
            default:   imm = {{20{hiField[11]}}, hiField};
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/top_proc_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port.
// Zero read latency, write visible the cycle after; x0 reads 0 and ignores writes.
module top_proc_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rdAddrA,
    input  logic [4:0]  rdAddrB,
    output logic [31:0] rdDataA,
    output logic [31:0] rdDataB,
    input  logic        wrEn,
    input  logic [4:0]  wrAddr,
    input  logic [31:0] wrData
);

    logic [31:0] regs [0:31];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wrEn && (wrAddr != 5'd0)) begin
            regs[wrAddr] <= wrData;
        end
    end

    assign rdDataA = (rdAddrA == 5'd0) ? 32'd0 : regs[rdAddrA];
    assign rdDataB = (rdAddrB == 5'd0) ? 32'd0 : regs[rdAddrB];

endmodule

// File: rtl/top_proc_core.sv
// Multicycle RV32I-subset core, IF-ID-EX-MEM-WB at one state per cycle (5 cycles/instr).
// No backpressure: ROM/RAM are synchronous and always ready. BNE gated by TOP_PROC_BNE_EN.
module top_proc_core
    import top_proc_pkg::*;
#(
    parameter logic [31:0] INITIAL_PC = INITIAL_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [31:0] dReadData,
    output logic [31:0] PC,
    output logic [31:0] dAddress,
    output logic [31:0] dWriteData,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] WriteBackData
);

    state_t      state;
    logic [31:0] instrReg;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [31:0] immReg;
    logic [31:0] rfRdA;
    logic [31:0] rfRdB;
    ctrl_t       ctrl;
    logic [31:0] aluB;
    logic [31:0] aluResult;
    logic        zero;
    logic        branchTaken;
    logic        rfWrEn;
    logic        unusedInstrBits;

    wire  [6:0]  opcode = instrReg[6:0];
    wire  [2:0]  funct3 = instrReg[14:12];
    wire  [4:0]  rd     = instrReg[11:7];

    // Operands are read straight off the ROM word during ID, then held for EX..WB.
    top_proc_regfile u_regfile (
        .clk     (clk),
        .rst     (rst),
        .rdAddrA (instr[19:15]),
        .rdAddrB (instr[24:20]),
        .rdDataA (rfRdA),
        .rdDataB (rfRdB),
        .wrEn    (rfWrEn),
        .wrAddr  (rd),
        .wrData  (WriteBackData)
    );

    always_comb begin
        aluOp_t f3Op;
        logic   f3Ok;
        ctrl  = '0;
        ctrl.aluOp = ALU_ADD;
        f3Ok  = 1'b1;
        case (funct3)
            3'b000:  f3Op = (instrReg[30] && opcode == OP_RTYPE) ? ALU_SUB : ALU_ADD;
            3'b001:  f3Op = ALU_SLL;
            3'b010:  f3Op = ALU_SLT;
            3'b100:  f3Op = ALU_XOR;
            3'b101:  f3Op = instrReg[30] ? ALU_SRA : ALU_SRL;
            3'b110:  f3Op = ALU_OR;
            3'b111:  f3Op = ALU_AND;
            default: begin
                f3Op = ALU_ADD;
                f3Ok = 1'b0;
            end
        endcase
        case (opcode)
            OP_RTYPE: begin
                ctrl.aluOp    = f3Op;
                ctrl.regWrite = f3Ok;
            end
            OP_ITYPE: begin
                ctrl.aluOp     = f3Op;
                ctrl.aluSrcImm = 1'b1;
                ctrl.regWrite  = f3Ok;
            end
            OP_LOAD: begin
                if (funct3 == 3'b010) begin
                    ctrl.aluSrcImm = 1'b1;
                    ctrl.regWrite  = 1'b1;
                    ctrl.memToReg  = 1'b1;
                    ctrl.memRead   = 1'b1;
                end
            end
            OP_STORE: begin
                if (funct3 == 3'b010) begin
                    ctrl.aluSrcImm = 1'b1;
                    ctrl.memWrite  = 1'b1;
                end
            end
            OP_BRANCH: begin
                ctrl.aluOp = ALU_SUB;
                if (funct3 == 3'b000) begin
                    ctrl.branchEq = 1'b1;
                end
`ifdef TOP_PROC_BNE_EN
                else if (funct3 == 3'b001) begin
                    ctrl.branchNe = 1'b1;
                end
`endif
            end
            default: ;
        endcase
    end

    assign aluB = ctrl.aluSrcImm ? immReg : opB;

    always_comb begin
        case (ctrl.aluOp)
            ALU_ADD: aluResult = opA + aluB;
            ALU_SUB: aluResult = opA - aluB;
            ALU_AND: aluResult = opA & aluB;
            ALU_OR:  aluResult = opA | aluB;
            ALU_XOR: aluResult = opA ^ aluB;
            ALU_SLL: aluResult = opA << aluB[4:0];
            ALU_SRL: aluResult = opA >> aluB[4:0];
            ALU_SRA: aluResult = $signed(opA) >>> aluB[4:0];
            ALU_SLT: aluResult = {31'd0, $signed(opA) < $signed(aluB)};
            default: aluResult = 32'd0;
        endcase
    end

    assign zero          = (aluResult == 32'd0);
    assign branchTaken   = (ctrl.branchEq && zero) || (ctrl.branchNe && !zero);
    assign dAddress      = aluResult;
    assign dWriteData    = opB;
    assign WriteBackData = ctrl.memToReg ? dReadData : aluResult;
    assign rfWrEn        = (state == ST_WB) && ctrl.regWrite;
    assign unusedInstrBits = ^{instrReg[31], instrReg[29:15]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IF;
            PC       <= INITIAL_PC;
            instrReg <= '0;
            opA      <= '0;
            opB      <= '0;
            immReg   <= '0;
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
        end else begin
            case (state)
                ST_IF: state <= ST_ID;
                ST_ID: begin
                    instrReg <= instr;
                    opA      <= rfRdA;
                    opB      <= rfRdB;
                    immReg   <= buildImm(instr[6:0], instr[31:20], instr[11:7]);
                    state    <= ST_EX;
                end
                ST_EX: begin
                    MemRead  <= ctrl.memRead;
                    MemWrite <= ctrl.memWrite;
                    state    <= ST_MEM;
                end
                ST_MEM: begin
                    MemRead  <= 1'b0;
                    MemWrite <= 1'b0;
                    state    <= ST_WB;
                end
                ST_WB: begin
                    PC    <= branchTaken ? (PC + immReg) : (PC + 32'd4);
                    state <= ST_IF;
                end
                default: state <= ST_IF;
            endcase
        end
    end

endmodule

// File: tb/tb_top_proc_core.sv
// Bench for top_proc_core: table of instructions run back to back with a scoreboard,
// plus hand-written reset sequences.
module tb_top_proc_core;

    localparam logic [31:0] INIT_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr = '0;
    logic [31:0] dReadData = '0;
    logic [31:0] PC;
    logic [31:0] dAddress;
    logic [31:0] dWriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] WriteBackData;

    top_proc_core #(.INITIAL_PC(INIT_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .instr         (instr),
        .dReadData     (dReadData),
        .PC            (PC),
        .dAddress      (dAddress),
        .dWriteData    (dWriteData),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .WriteBackData (WriteBackData)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] rdData;
        logic        chkWb;
        logic [31:0] wb;
        logic        mRd;
        logic        mWr;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic [31:0] pcDelta;
    } vec_t;

    vec_t        vecs[$];
    vec_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] expPc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [31:0] ins, input logic [31:0] wb,
                                input logic [31:0] pcDelta);
        vec_t v;
        v.ins = ins; v.rdData = 32'hDEAD_BEEF; v.chkWb = 1'b1; v.wb = wb;
        v.mRd = 1'b0; v.mWr = 1'b0; v.addr = '0; v.wdat = '0; v.pcDelta = pcDelta;
        return v;
    endfunction

    task automatic runVec(input vec_t v);
        vec_t cur;
        check("pc_at_if", PC, expPc);
        instr     = v.ins;
        dReadData = v.rdData;
        sb.push_back(v);
        stepEdge();
        stepEdge();
        check("memwrite_in_ex", {31'd0, MemWrite}, 32'd0);
        stepEdge();
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
            return;
        end
        cur = sb.pop_front();
        check("memread_mem", {31'd0, MemRead}, {31'd0, cur.mRd});
        check("memwrite_mem", {31'd0, MemWrite}, {31'd0, cur.mWr});
        if (cur.mRd || cur.mWr) check("daddress_mem", dAddress, cur.addr);
        if (cur.mWr) check("dwritedata_mem", dWriteData, cur.wdat);
        stepEdge();
        if (cur.chkWb) check($sformatf("wb_%h", cur.ins), WriteBackData, cur.wb);
        check("memread_wb", {31'd0, MemRead}, 32'd0);
        check("pc_stable_wb", PC, expPc);
        stepEdge();
        expPc = expPc + cur.pcDelta;
    endtask

    initial begin
        vec_t v;
        vecs.push_back(mk(32'h00500093, 32'd5, 32'd4));           // ADDI x1,x0,5
        vecs.push_back(mk(32'h00108133, 32'd10, 32'd4));          // ADD x2,x1,x1
        v = mk(32'h00202423, 32'd8, 32'd4);                       // SW x2,8(x0)
        v.mWr = 1'b1; v.addr = 32'd8; v.wdat = 32'd10;
        vecs.push_back(v);
        v = mk(32'h00802183, 32'd10, 32'd4);                      // LW x3,8(x0)
        v.rdData = 32'd10; v.mRd = 1'b1; v.addr = 32'd8;
        vecs.push_back(v);
        vecs.push_back(mk(32'h00018433, 32'd10, 32'd4));          // ADD x8,x3,x0
        vecs.push_back(mk(32'h00108463, 32'd0, 32'd8));           // BEQ x1,x1,+8 taken
        vecs.push_back(mk(32'h00208463, 32'hFFFF_FFFB, 32'd4));   // BEQ x1,x2 not taken
`ifdef TOP_PROC_BNE_EN
        vecs.push_back(mk(32'h00209463, 32'hFFFF_FFFB, 32'd8));   // BNE x1,x2 taken
`else
        vecs.push_back(mk(32'h00209463, 32'hFFFF_FFFB, 32'd4));   // BNE is a NOP
`endif
        vecs.push_back(mk(32'hff800213, 32'hFFFF_FFF8, 32'd4));   // ADDI x4,x0,-8
        vecs.push_back(mk(32'h40125293, 32'hFFFF_FFFC, 32'd4));   // SRAI x5,x4,1
        vecs.push_back(mk(32'h00022333, 32'd1, 32'd4));           // SLT x6,x4,x0
        vecs.push_back(mk(32'hFFF22813, 32'd1, 32'd4));           // SLTI x16,x4,-1
        vecs.push_back(mk(32'h0FF27893, 32'h0000_00F8, 32'd4));   // ANDI x17,x4,0xff
        vecs.push_back(mk(32'h402084B3, 32'hFFFF_FFFB, 32'd4));   // SUB x9,x1,x2
        vecs.push_back(mk(32'h0020C533, 32'd15, 32'd4));          // XOR x10,x1,x2
        vecs.push_back(mk(32'h0020F5B3, 32'd0, 32'd4));           // AND x11,x1,x2
        vecs.push_back(mk(32'h0020E633, 32'd15, 32'd4));          // OR x12,x1,x2
        vecs.push_back(mk(32'h001096B3, 32'h0000_00A0, 32'd4));   // SLL x13,x1,x1
        vecs.push_back(mk(32'h00125733, 32'h07FF_FFFF, 32'd4));   // SRL x14,x4,x1
        vecs.push_back(mk(32'h00700013, 32'd7, 32'd4));           // ADDI x0,x0,7
        vecs.push_back(mk(32'h000003B3, 32'd0, 32'd4));           // ADD x7,x0,x0
        v = mk(32'h000000FF, 32'd0, 32'd4);                       // unknown opcode, rd=x1
        v.chkWb = 1'b0;
        vecs.push_back(v);
        vecs.push_back(mk(32'h000087B3, 32'd5, 32'd4));           // ADD x15,x1,x0

        // Reset held across several edges
        rst = 1'b0;
        repeat (3) stepEdge();
        check("reset_pc", PC, INIT_PC);
        check("reset_memread", {31'd0, MemRead}, 32'd0);
        check("reset_memwrite", {31'd0, MemWrite}, 32'd0);
        rst = 1'b1;
        expPc = INIT_PC;

        foreach (vecs[i]) runVec(vecs[i]);

        // Reset asserted in EX aborts the instruction
        check("pc_before_abort", PC, expPc);
        instr = 32'h00900093;                                    // ADDI x1,x0,9
        stepEdge();
        stepEdge();
        rst = 1'b0;
        #1;
        check("abort_pc", PC, INIT_PC);
        check("abort_memread", {31'd0, MemRead}, 32'd0);
        check("abort_memwrite", {31'd0, MemWrite}, 32'd0);
        stepEdge();
        rst = 1'b1;
        expPc = INIT_PC;
        runVec(mk(32'h00008933, 32'd0, 32'd4));                  // ADD x18,x1,x0
        runVec(mk(32'h00500093, 32'd5, 32'd4));                  // ADDI x1,x0,5 again
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
